// File: rtl/mul_sequencer_pkg.sv
// Shared constants and state type for the iterative MUL sequencer in EX.
package mul_sequencer_pkg;

  localparam int unsigned MULSEQ_CNT_W = 6;

  typedef enum logic [1:0] {
    MULSEQ_IDLE = 2'd0,
    MULSEQ_RUN  = 2'd1,
    MULSEQ_DONE = 2'd2
  } mulseq_state_t;

endpackage

// File: rtl/mul_shift_add_step.sv
// One shift-add multiply iteration: conditional accumulate, then shift both operands.
module mul_shift_add_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc_nxt,
  output logic [WIDTH-1:0] o_mcand_nxt,
  output logic [WIDTH-1:0] o_mplier_nxt,
  output logic             o_mplier_zero
);

  assign o_acc_nxt     = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
  assign o_mcand_nxt   = i_mcand << 1;
  assign o_mplier_nxt  = i_mplier >> 1;
  // Zero flag refers to the shifted multiplier so RUN can exit early.
  assign o_mplier_zero = (o_mplier_nxt == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Shift-add MUL controller: holds the pipeline via stall request until the low product is ready.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = MULSEQ_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_start,
  input  logic             ex_flush,
  input  logic [WIDTH-1:0] ex_rs_data,
  input  logic [WIDTH-1:0] ex_rt_data,
  input  logic [4:0]       ex_rd,
  output logic             mul_stall_req,
  output logic             mul_busy,
  output logic             mul_result_valid,
  output logic [WIDTH-1:0] mul_result,
  output logic [4:0]       mul_result_rd
);

  mulseq_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [4:0]       r_rd;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_result_rd;

  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic             w_mplier_zero;
  logic             w_zero_op;
  logic             w_run_exit;

  mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .i_acc         (r_acc),
    .i_mcand       (r_mcand),
    .i_mplier      (r_mplier),
    .o_acc_nxt     (w_acc_nxt),
    .o_mcand_nxt   (w_mcand_nxt),
    .o_mplier_nxt  (w_mplier_nxt),
    .o_mplier_zero (w_mplier_zero)
  );

  assign w_zero_op  = (ex_rs_data == '0) || (ex_rt_data == '0);
  assign w_run_exit = (r_cnt == CNT_W'(WIDTH - 1)) || w_mplier_zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= MULSEQ_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rd        <= '0;
      r_result    <= '0;
      r_result_rd <= '0;
    end else if (ex_flush) begin
      r_state <= MULSEQ_IDLE;
    end else begin
      case (r_state)
        MULSEQ_IDLE, MULSEQ_DONE: begin
          if (ex_start) begin
            r_mcand  <= ex_rs_data;
            r_mplier <= ex_rt_data;
            r_rd     <= ex_rd;
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_zero_op) begin
              // Zero shortcut: result is known now, publish it with the tag directly.
              r_state     <= MULSEQ_DONE;
              r_result    <= '0;
              r_result_rd <= ex_rd;
            end else begin
              r_state <= MULSEQ_RUN;
            end
          end else begin
            r_state <= MULSEQ_IDLE;
          end
        end
        MULSEQ_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= w_mcand_nxt;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_run_exit) begin
            r_state     <= MULSEQ_DONE;
            r_result    <= w_acc_nxt;
            r_result_rd <= r_rd;
          end
        end
        default: r_state <= MULSEQ_IDLE;
      endcase
    end
  end

  assign mul_busy         = (r_state == MULSEQ_RUN);
  assign mul_result_valid = (r_state == MULSEQ_DONE);
  assign mul_stall_req    = ((r_state == MULSEQ_IDLE) && ex_start) ||
                            (r_state == MULSEQ_RUN) ||
                            ((r_state == MULSEQ_DONE) && ex_start);
  assign mul_result       = r_result;
  assign mul_result_rd    = r_result_rd;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: scoreboard of expected products, tags and arrival cycles.
module tb_mul_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_start = 1'b0;
  logic        ex_flush = 1'b0;
  logic [31:0] ex_rs_data = '0;
  logic [31:0] ex_rt_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        mul_stall_req;
  logic        mul_busy;
  logic        mul_result_valid;
  logic [31:0] mul_result;
  logic [4:0]  mul_result_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nvalid;
  int   t0;

  mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_start         (ex_start),
    .ex_flush         (ex_flush),
    .ex_rs_data       (ex_rs_data),
    .ex_rt_data       (ex_rt_data),
    .ex_rd            (ex_rd),
    .mul_stall_req    (mul_stall_req),
    .mul_busy         (mul_busy),
    .mul_result_valid (mul_result_valid),
    .mul_result       (mul_result),
    .mul_result_rd    (mul_result_rd)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle (negedge) of the next cycle.
  task automatic cycle();
    @(negedge clock);
    cyc++;
  endtask

  function automatic int latency(input logic [31:0] a, input logic [31:0] b);
    int hb;
    hb = 0;
    if (a == 32'd0 || b == 32'd0) return 1;
    for (int i = 0; i < 32; i++) if (b[i]) hb = i;
    return hb + 2;
  endfunction

  // Drive a start in the current cycle and enqueue its expected outcome.
  task automatic start_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input bit expect_result);
    exp_t e;
    ex_start   = 1'b1;
    ex_rs_data = a;
    ex_rt_data = b;
    ex_rd      = rd;
    if (expect_result) begin
      e.res = a * b;
      e.rd  = rd;
      e.due = cyc + latency(a, b);
      sb.push_back(e);
    end
    #1;
    chk("stall_on_start", 32'(mul_stall_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    exp_t e;
    for (int i = 0; i < budget; i++) begin
      if (mul_result_valid) break;
      cycle();
    end
    #1;
    chk({tag, "_valid"}, 32'(mul_result_valid), 32'd1);
    if (mul_result_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, mul_result, e.res);
      chk({tag, "_rd"}, 32'(mul_result_rd), 32'(e.rd));
      chk({tag, "_latency"}, 32'(cyc), 32'(e.due));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset held two cycles.
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    #1;
    chk("rst_stall", 32'(mul_stall_req), 32'd0);
    chk("rst_busy", 32'(mul_busy), 32'd0);
    chk("rst_valid", 32'(mul_result_valid), 32'd0);
    chk("rst_result", mul_result, 32'd0);
    chk("rst_rd", 32'(mul_result_rd), 32'd0);

    // 7*6: early exit, valid at T+4.
    cycle();
    start_mul(32'd7, 32'd6, 5'd9, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      ex_start = 1'b0;
      #1;
      chk("a_stall_run", 32'(mul_stall_req), 32'd1);
      chk("a_busy_run", 32'(mul_busy), 32'd1);
    end
    cycle();
    wait_valid("a", 10);
    chk("a_stall_done", 32'(mul_stall_req), 32'd0);
    cycle();
    #1;
    chk("a_valid_pulse", 32'(mul_result_valid), 32'd0);
    chk("a_result_hold", mul_result, 32'd42);

    // All-ones operands: full-length RUN, valid at T+33.
    cycle();
    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1);
    cycle();
    ex_start = 1'b0;
    wait_valid("b", 40);

    // Zero shortcut, then back-to-back start in its DONE cycle.
    cycle();
    cycle();
    start_mul(32'd0, 32'd123, 5'd3, 1'b1);
    cycle();
    ex_start = 1'b0;
    #1;
    chk("z_stall_done", 32'(mul_stall_req), 32'd0);
    wait_valid("z", 5);
    start_mul(32'd3, 32'd5, 5'd4, 1'b1);
    cycle();
    ex_start = 1'b0;
    #1;
    chk("bb_no_idle_gap", 32'(mul_busy), 32'd1);
    wait_valid("bb", 10);

    // Flush mid-RUN: no result, output registers keep last value.
    cycle();
    cycle();
    t0 = cyc;
    start_mul(32'd1000, 32'h8000_0000, 5'd7, 1'b0);
    while (cyc < t0 + 5) begin
      cycle();
      ex_start = 1'b0;
    end
    ex_flush = 1'b1;
    cycle();
    ex_flush = 1'b0;
    #1;
    chk("fl_stall_drop", 32'(mul_stall_req), 32'd0);
    chk("fl_busy_drop", 32'(mul_busy), 32'd0);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      if (mul_result_valid) nvalid++;
      cycle();
    end
    chk("fl_no_valid", 32'(nvalid), 32'd0);
    chk("fl_result_hold", mul_result, 32'd15);
    chk("fl_rd_hold", 32'(mul_result_rd), 32'd4);

    // Same abort via reset: registers cleared.
    t0 = cyc;
    start_mul(32'd1000, 32'h8000_0000, 5'd7, 1'b0);
    while (cyc < t0 + 5) begin
      cycle();
      ex_start = 1'b0;
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("rs_stall_drop", 32'(mul_stall_req), 32'd0);
    chk("rs_busy_drop", 32'(mul_busy), 32'd0);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      if (mul_result_valid) nvalid++;
      cycle();
    end
    chk("rs_no_valid", 32'(nvalid), 32'd0);
    chk("rs_result_clr", mul_result, 32'd0);
    chk("rs_rd_clr", 32'(mul_result_rd), 32'd0);

    // Simultaneous start and flush in IDLE: start dropped.
    ex_start   = 1'b1;
    ex_flush   = 1'b1;
    ex_rs_data = 32'd9;
    ex_rt_data = 32'd9;
    ex_rd      = 5'd1;
    cycle();
    ex_start = 1'b0;
    ex_flush = 1'b0;
    #1;
    chk("sf_busy", 32'(mul_busy), 32'd0);
    chk("sf_valid", 32'(mul_result_valid), 32'd0);

    // Start during RUN is ignored.
    cycle();
    start_mul(32'd100, 32'h30, 5'd11, 1'b1);
    cycle();
    ex_start = 1'b0;
    cycle();
    ex_start   = 1'b1;
    ex_rs_data = 32'd5;
    ex_rt_data = 32'd9;
    ex_rd      = 5'd22;
    cycle();
    ex_start = 1'b0;
    wait_valid("ign", 40);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
